// File: rtl/sad_row_feeder.sv
// sad_row_feeder: upstream half of the SAD datapath.
//   Accepts streamed (cur, ref) pixel pairs, forms |cur-ref|, and parks each
//   result in one of eight registered operand lanes (o_P0..o_P7) that feed
//   the external 8-operand compressor array. After eight pairs the returned
//   row sum is sampled for one cycle (SUM) and accumulated. After ROWS rows
//   the block SAD is offered downstream on a valid/ready handshake.
// Ports:
//   i_clk, i_rst_n          clock, async active-low reset
//   i_valid/o_ready         pixel pair handshake, i_cur/i_ref pixel pair
//   o_P0..o_P7              absolute-difference lanes to compressor array
//   i_row_sum               combinational sum of the lanes from the array
//   o_sad_valid/i_sad_ready block SAD handshake, o_sad block SAD
//   o_row_idx               row currently being collected

module sad_lane_reg #(
  parameter int PIX_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             load,
  input  logic [PIX_W-1:0] d,
  output logic [PIX_W-1:0] q
);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n)  q <= '0;
    else if (load) q <= d;
endmodule

module sad_row_feeder #(
  parameter int PIX_W = 8,
  parameter int ROWS  = 8,
  parameter int ACC_W = 14
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic                                 i_valid,
  output logic                                 o_ready,
  input  logic [PIX_W-1:0]                     i_cur,
  input  logic [PIX_W-1:0]                     i_ref,
  output logic [PIX_W-1:0]                     o_P0,
  output logic [PIX_W-1:0]                     o_P1,
  output logic [PIX_W-1:0]                     o_P2,
  output logic [PIX_W-1:0]                     o_P3,
  output logic [PIX_W-1:0]                     o_P4,
  output logic [PIX_W-1:0]                     o_P5,
  output logic [PIX_W-1:0]                     o_P6,
  output logic [PIX_W-1:0]                     o_P7,
  input  logic [PIX_W+2:0]                     i_row_sum,
  output logic                                 o_sad_valid,
  input  logic                                 i_sad_ready,
  output logic [ACC_W-1:0]                     o_sad,
  output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] o_row_idx
);
  localparam int NUM_LANES = 8;
  localparam int RW        = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {COLLECT, SUM, DONE} state_t;

  state_t                             state, state_nxt;
  logic [2:0]                         lane_idx;
  logic [RW-1:0]                      row_cnt;
  logic [ACC_W-1:0]                   acc;
  logic [NUM_LANES-1:0][PIX_W-1:0]    lane;
  logic [PIX_W:0]                     diff_p, diff_n;
  logic [PIX_W-1:0]                   ad;
  logic [ACC_W-1:0]                   rs_ext;
  logic                               xfer, last_row;

  // Both orderings at PIX_W+1; the borrow bit of cur-ref picks the positive one.
  assign diff_p = {1'b0, i_cur} - {1'b0, i_ref};
  assign diff_n = {1'b0, i_ref} - {1'b0, i_cur};
  assign ad     = diff_p[PIX_W] ? diff_n[PIX_W-1:0] : diff_p[PIX_W-1:0];

  assign xfer     = i_valid && o_ready;
  assign rs_ext   = {{(ACC_W-PIX_W-3){1'b0}}, i_row_sum};
  assign last_row = (row_cnt == RW'(ROWS-1));

  // One register per lane; only the lane addressed by lane_idx loads.
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    sad_lane_reg #(.PIX_W(PIX_W)) u_lane (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .load    (xfer && (lane_idx == 3'(k))),
      .d       (ad),
      .q       (lane[k])
    );
  end

  assign o_P0 = lane[0];
  assign o_P1 = lane[1];
  assign o_P2 = lane[2];
  assign o_P3 = lane[3];
  assign o_P4 = lane[4];
  assign o_P5 = lane[5];
  assign o_P6 = lane[6];
  assign o_P7 = lane[7];
  assign o_row_idx = row_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state <= COLLECT;
    else          state <= state_nxt;

  always_comb begin
    state_nxt = state;
    o_ready   = 1'b0;
    case (state)
      COLLECT: begin
        o_ready = 1'b1;
        if (xfer && lane_idx == 3'd7) state_nxt = SUM;
      end
      SUM:     state_nxt = last_row ? DONE : COLLECT;
      DONE:    if (i_sad_ready) state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      lane_idx    <= '0;
      row_cnt     <= '0;
      acc         <= '0;
      o_sad       <= '0;
      o_sad_valid <= 1'b0;
    end else begin
      case (state)
        COLLECT: if (xfer) lane_idx <= lane_idx + 3'd1;  // wraps 7 -> 0
        SUM: begin
          acc <= acc + rs_ext;
          if (last_row) begin
            row_cnt     <= '0;
            o_sad       <= acc + rs_ext;
            o_sad_valid <= 1'b1;
          end else begin
            row_cnt <= row_cnt + RW'(1);
          end
        end
        DONE: if (i_sad_ready) begin
          acc         <= '0;
          o_sad_valid <= 1'b0;  // o_sad keeps the last block value
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_sad_row_feeder.sv
module tb_sad_row_feeder;
  localparam int PIX_W = 8;
  localparam int ROWS  = 8;
  localparam int ACC_W = 14;
  localparam int NPAIR = ROWS * 8;

  logic             i_clk = 1'b0;
  logic             i_rst_n = 1'b0;
  logic             i_valid = 1'b0;
  logic             o_ready;
  logic [7:0]       i_cur = '0, i_ref = '0;
  logic [7:0]       o_P0, o_P1, o_P2, o_P3, o_P4, o_P5, o_P6, o_P7;
  logic [10:0]      i_row_sum;
  logic             o_sad_valid;
  logic             i_sad_ready = 1'b0;
  logic [ACC_W-1:0] o_sad;
  logic [2:0]       o_row_idx;

  int tests = 0;
  int fails = 0;

  logic [7:0] cur_a [NPAIR];
  logic [7:0] ref_a [NPAIR];
  logic [7:0] p [8];
  int         last_sad;

  always #5 i_clk = ~i_clk;

  // Behavioural compressor array: plain sum of the eight lanes.
  assign i_row_sum = 11'(o_P0) + 11'(o_P1) + 11'(o_P2) + 11'(o_P3)
                   + 11'(o_P4) + 11'(o_P5) + 11'(o_P6) + 11'(o_P7);
  assign p[0] = o_P0; assign p[1] = o_P1; assign p[2] = o_P2; assign p[3] = o_P3;
  assign p[4] = o_P4; assign p[5] = o_P5; assign p[6] = o_P6; assign p[7] = o_P7;

  sad_row_feeder #(.PIX_W(PIX_W), .ROWS(ROWS), .ACC_W(ACC_W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_cur(i_cur), .i_ref(i_ref),
    .o_P0(o_P0), .o_P1(o_P1), .o_P2(o_P2), .o_P3(o_P3),
    .o_P4(o_P4), .o_P5(o_P5), .o_P6(o_P6), .o_P7(o_P7),
    .i_row_sum(i_row_sum), .o_sad_valid(o_sad_valid), .i_sad_ready(i_sad_ready),
    .o_sad(o_sad), .o_row_idx(o_row_idx)
  );

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  // Reference SAD of the loaded block: sum of |cur-ref| over all pairs.
  function automatic int model_sad();
    int s = 0;
    for (int i = 0; i < NPAIR; i++) s += absd(int'(cur_a[i]), int'(ref_a[i]));
    return s;
  endfunction

  // Push the loaded block through the DUT, checking handshake, lanes in each
  // SUM cycle, and the SAD handshake with `hold` cycles of backpressure.
  task automatic run_block(input int gap_pct, input int hold, input string tag);
    int exp_sad;
    int k, guard, e;
    exp_sad = model_sad();
    for (int r = 0; r < ROWS; r++) begin
      k = 0; guard = 0;
      while (k < 8) begin
        @(negedge i_clk);
        i_valid = ($urandom_range(99) >= gap_pct);
        i_cur = cur_a[r*8+k];
        i_ref = ref_a[r*8+k];
        tests++;
        if (o_ready !== 1'b1 || o_row_idx !== 3'(r)) begin
          fails++;
          $display("FAIL %s collect r%0d: ready=%b row_idx=%0d, want ready=1 row_idx=%0d",
                   tag, r, o_ready, o_row_idx, r);
        end
        if (i_valid) k++;
        guard++;
        if (guard > 400) begin
          tests++; fails++;
          $display("FAIL %s timeout in row %0d", tag, r);
          i_valid = 1'b0;
          return;
        end
      end
      // SUM cycle: offer a junk pair that must be ignored.
      @(negedge i_clk);
      i_valid = 1'b1;
      i_cur = 8'($urandom);
      i_ref = 8'($urandom);
      tests++;
      if (o_ready !== 1'b0 || o_sad_valid !== 1'b0) begin
        fails++;
        $display("FAIL %s sum r%0d: ready=%b sad_valid=%b, want 0 0", tag, r, o_ready, o_sad_valid);
      end
      for (int j = 0; j < 8; j++) begin
        e = absd(int'(cur_a[r*8+j]), int'(ref_a[r*8+j]));
        tests++;
        if (p[j] !== 8'(e)) begin
          fails++;
          $display("FAIL %s lane r%0d P%0d: got %0d want %0d", tag, r, j, p[j], e);
        end
      end
    end
    // DONE
    @(negedge i_clk);
    tests++;
    if (o_sad_valid !== 1'b1 || o_sad !== ACC_W'(exp_sad) || o_ready !== 1'b0 || o_row_idx !== 3'd0) begin
      fails++;
      $display("FAIL %s done: valid=%b sad=%0d ready=%b row=%0d, want 1 %0d 0 0",
               tag, o_sad_valid, o_sad, o_ready, o_row_idx, exp_sad);
    end
    i_sad_ready = (hold == 0);
    for (int h = 1; h <= hold; h++) begin
      @(negedge i_clk);
      i_valid = 1'b1;
      tests++;
      if (o_sad_valid !== 1'b1 || o_sad !== ACC_W'(exp_sad) || o_ready !== 1'b0) begin
        fails++;
        $display("FAIL %s hold %0d: valid=%b sad=%0d ready=%b, want 1 %0d 0",
                 tag, h, o_sad_valid, o_sad, o_ready, exp_sad);
      end
      if (h == hold) i_sad_ready = 1'b1;
    end
    @(negedge i_clk);
    tests++;
    if (o_sad_valid !== 1'b0 || o_sad !== ACC_W'(exp_sad) || o_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s release: valid=%b sad=%0d ready=%b, want 0 %0d 1",
               tag, o_sad_valid, o_sad, o_ready, exp_sad);
    end
    i_sad_ready = 1'b0;
    i_valid = 1'b0;
    last_sad = exp_sad;
  endtask

  task automatic fill_random();
    for (int i = 0; i < NPAIR; i++) begin
      cur_a[i] = 8'($urandom);
      ref_a[i] = 8'($urandom);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    tests++;
    if (o_P0 !== 0 || o_P1 !== 0 || o_P2 !== 0 || o_P3 !== 0 || o_P4 !== 0 ||
        o_P5 !== 0 || o_P6 !== 0 || o_P7 !== 0 || o_sad !== 0 ||
        o_sad_valid !== 1'b0 || o_row_idx !== 3'd0) begin
      fails++;
      $display("FAIL %s: lanes %0d %0d %0d %0d %0d %0d %0d %0d sad=%0d valid=%b row=%0d, want all 0",
               tag, o_P0, o_P1, o_P2, o_P3, o_P4, o_P5, o_P6, o_P7, o_sad, o_sad_valid, o_row_idx);
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    repeat (3) @(negedge i_clk);
    check_zero_outputs("reset_state");
    i_rst_n = 1'b1;
    @(negedge i_clk);
    tests++;
    if (o_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: got %b want 1", o_ready);
    end
  endtask

  task automatic test_equal();
    for (int i = 0; i < NPAIR; i++) begin cur_a[i] = 8'd37; ref_a[i] = 8'd37; end
    run_block(0, 0, "equal");
  endtask

  task automatic test_max();
    for (int i = 0; i < NPAIR; i++) begin cur_a[i] = 8'd255; ref_a[i] = 8'd0; end
    run_block(0, 0, "max_fwd");
    tests++;
    if (o_sad !== 14'd16320) begin
      fails++; $display("FAIL max_fwd_total: got %0d want 16320", o_sad);
    end
    for (int i = 0; i < NPAIR; i++) begin cur_a[i] = 8'd0; ref_a[i] = 8'd255; end
    run_block(0, 0, "max_rev");
    tests++;
    if (o_sad !== 14'd16320) begin
      fails++; $display("FAIL max_rev_total: got %0d want 16320", o_sad);
    end
  endtask

  task automatic test_pattern();
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < 8; k++) begin
        cur_a[r*8+k] = 8'(k * 10);
        ref_a[r*8+k] = 8'(r);
      end
    run_block(0, 0, "pattern");
  endtask

  task automatic test_gaps();
    int ref_sad;
    fill_random();
    run_block(0, 0, "gapfree");
    ref_sad = int'(o_sad);
    run_block(40, 0, "gapped");
    tests++;
    if (int'(o_sad) !== ref_sad) begin
      fails++; $display("FAIL gap_equal: got %0d want %0d", o_sad, ref_sad);
    end
  endtask

  task automatic test_back_to_back_hold();
    fill_random();
    run_block(0, 6, "backpressure");
    fill_random();
    run_block(20, 0, "after_hold");
  endtask

  task automatic test_reset_mid_block();
    int acc_n;
    fill_random();
    acc_n = 0;
    // 2 full rows plus 3 pairs of row 2
    while (acc_n < 19) begin
      @(negedge i_clk);
      i_valid = 1'b1;
      i_cur = 8'($urandom | 1);
      i_ref = 8'd0;
      if (o_ready) acc_n++;
    end
    @(negedge i_clk);
    i_valid = 1'b0;
    i_rst_n = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    @(negedge i_clk);
    i_rst_n = 1'b1;
    run_block(0, 0, "post_reset");
  endtask

  initial begin
    test_reset();
    test_equal();
    test_max();
    test_pattern();
    test_gaps();
    test_back_to_back_hold();
    test_reset_mid_block();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/sad_row_feeder.md
Name: sad_row_feeder

Overview:
- Upstream half of the SAD datapath. Accepts streamed current/reference pixel pairs and forms |cur-ref| for each pair.
- Packs eight absolute differences into the operand lanes of the 8-operand compressor array, then captures that array's 11-bit row sum.
- Accumulates row sums over a block of ROWS rows and hands the block SAD downstream with a valid/ready handshake.

Parameters:
- PIX_W, 8, pixel width; lane width equals PIX_W.
- ROWS, 8, rows of eight pixel pairs per block (>=1).
- ACC_W, 14, accumulator/result width; must be >= PIX_W+3+clog2(ROWS).

Ports:
- i_clk  in  1  single clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  pixel pair valid.
- o_ready  out  1  feeder accepts a pair this cycle.
- i_cur  in  PIX_W  current-block pixel.
- i_ref  in  PIX_W  reference-block pixel.
- o_P0..o_P7  out  PIX_W each  registered absolute-difference lanes to compressor array.
- i_row_sum  in  PIX_W+3  combinational sum of o_P0..o_P7 returned by compressor array.
- o_sad_valid  out  1  block SAD available.
- i_sad_ready  in  1  downstream accepts SAD.
- o_sad  out  ACC_W  block SAD.
- o_row_idx  out  clog2(ROWS) (min 1)  row currently being collected (debug/status).

Behaviour:
- Reset (async, i_rst_n=0): state=COLLECT, lane index=0, row counter=0, accumulator=0, o_P0..o_P7=0, o_sad=0, o_sad_valid=0. o_ready=1 immediately after deassertion. Reset mid-block discards all partial data; no partial SAD is ever emitted.
- Transfer occurs when i_valid&&o_ready. When o_ready=0, i_valid/i_cur/i_ref are ignored. i_valid may drop at any time with no effect on state.
- Abs diff: unsigned, |i_cur-i_ref| computed at PIX_W+1 internally and truncated to PIX_W. Equal inputs give 0; 0 vs 255 gives 255 in either order.
- Lane order: the k-th accepted pair in a row (k=0..7) is registered into o_Pk on the transfer edge. The other lanes hold their values.
- FSM:
  - COLLECT: o_ready=1. On each transfer, lane index increments; on the 8th transfer (index 7) index wraps to 0 and state goes to SUM.
  - SUM (exactly 1 cycle): o_ready=0; lanes stable. At the end of this cycle, accumulator += zero-extended i_row_sum. If row counter==ROWS-1: row counter clears, o_sad <= accumulator+i_row_sum, o_sad_valid <= 1, state goes to DONE. Otherwise row counter increments and state returns to COLLECT.
  - DONE: o_ready=0; o_sad and o_sad_valid held stable. On i_sad_ready=1 the accumulator clears, o_sad_valid <= 0 (o_sad keeps its last value), and state goes to COLLECT. A new block may start the next cycle.
- Lanes persist until overwritten; the compressor sees stale upper lanes during collection. Only the value sampled in SUM counts.
- Timing:
  - Best-case throughput is 9 cycles per row: 8 transfers plus 1 SUM.
  - Block SAD appears with o_sad_valid rising 1 edge after the last row's SUM cycle begins.
  - ROWS=1: DONE follows every single row.
- Width: max row sum 8*(2^PIX_W-1)=2040 fits PIX_W+3. Max block sum 2040*ROWS fits ACC_W; no saturation or wrap logic is required.
- o_row_idx reflects the row counter. It is 0 in DONE and after reset.
- i_row_sum is assumed combinational from o_P*. The feeder adds no extra pipeline register on it.

Test Plan:
- All 64 pairs cur=ref=37, i_valid held high, i_sad_ready=1 -> o_sad=0 with o_sad_valid pulse; o_ready low exactly on each SUM cycle and the DONE cycle.
- All 64 pairs cur=255, ref=0 -> each row sum 2040; o_sad=16320 (0x3FC0). Repeat with cur=0, ref=255 -> identical result.
- Row r pair k: cur=k*10, ref=r -> o_Pk=|10k-r| observed in SUM. o_sad = sum over r=0..7 and k=0..7 of |10k-r|, checked against the reference model.
- Random i_valid gaps (about 40% idle) with random pixels -> o_sad identical to the gap-free run. No pair is lost or duplicated.
- Hold i_sad_ready=0 for 6 cycles in DONE while driving i_valid=1 -> o_sad and o_sad_valid stable, o_ready=0, no input consumed. On release the next block's first pair lands in o_P0.
- Assert i_rst_n=0 after the 3rd pair of row 2 -> all outputs 0 asynchronously. A subsequent full block yields the correct SAD with no residue from the aborted block.
